// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the fan controller front-end: FSM encoding,
// coefficient register map and default ADC handshake timeout.
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_REQ    = 2'd2,
        ST_STROBE = 2'd3
    } state_t;

    localparam logic [2:0] ADDR_A0 = 3'd0;
    localparam logic [2:0] ADDR_A1 = 3'd1;
    localparam logic [2:0] ADDR_B0 = 3'd2;
    localparam logic [2:0] ADDR_B1 = 3'd3;
    localparam logic [2:0] ADDR_B2 = 3'd4;

    localparam int NUM_COEFFS             = 5;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Counter width able to hold 0..cycles-1 (at least one bit).
    function automatic int timeout_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/fan_ctrl_scheduler_if.sv
// Signal bundle between the fan controller scheduler and its environment
// (run control, ADC handshake, coefficient config port, PWM/PID outputs).
interface fan_ctrl_scheduler_if #(
    parameter int ADC_BITWIDTH        = 8,
    parameter int REG_BITWIDTH        = 5,
    parameter int PRESCALE_BITWIDTH   = 8,
    parameter int SAMPLE_DIV_BITWIDTH = 8
);
    logic                           enable_i;
    logic [PRESCALE_BITWIDTH-1:0]   prescale_i;
    logic [SAMPLE_DIV_BITWIDTH-1:0] sample_div_i;

    logic                           adc_req_o;
    logic                           adc_valid_i;
    logic [ADC_BITWIDTH-1:0]        adc_data_i;

    logic                           cfg_we_i;
    logic [2:0]                     cfg_addr_i;
    logic signed [REG_BITWIDTH-1:0] cfg_wdata_i;
    logic                           cfg_commit_i;

    logic                           clk_en_PWM_o;
    logic                           dataValid_STRB_o;
    logic [ADC_BITWIDTH-1:0]        ADC_value_o;
    logic signed [REG_BITWIDTH-1:0] a0_o;
    logic signed [REG_BITWIDTH-1:0] a1_o;
    logic signed [REG_BITWIDTH-1:0] b0_o;
    logic signed [REG_BITWIDTH-1:0] b1_o;
    logic signed [REG_BITWIDTH-1:0] b2_o;
    logic                           commit_pending_o;
    logic                           timeout_err_o;

    modport master (
        output enable_i, prescale_i, sample_div_i,
        output adc_valid_i, adc_data_i,
        output cfg_we_i, cfg_addr_i, cfg_wdata_i, cfg_commit_i,
        input  adc_req_o, clk_en_PWM_o, dataValid_STRB_o, ADC_value_o,
        input  a0_o, a1_o, b0_o, b1_o, b2_o, commit_pending_o, timeout_err_o
    );

    modport slave (
        input  enable_i, prescale_i, sample_div_i,
        input  adc_valid_i, adc_data_i,
        input  cfg_we_i, cfg_addr_i, cfg_wdata_i, cfg_commit_i,
        output adc_req_o, clk_en_PWM_o, dataValid_STRB_o, ADC_value_o,
        output a0_o, a1_o, b0_o, b1_o, b2_o, commit_pending_o, timeout_err_o
    );

endinterface

// File: rtl/fan_ctrl_coeff_bank.sv
// PID coefficient bank: writes land in shadow regs; a commit stays pending until the sequencer
// raises apply at a safe point, then all five active regs update together one cycle later.
module fan_ctrl_coeff_bank
    import fan_ctrl_pkg::*;
#(
    parameter int REG_BITWIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we,
    input  logic [2:0]                     addr,
    input  logic signed [REG_BITWIDTH-1:0] wdata,
    input  logic                           commit,
    input  logic                           apply,
    output logic                           pending,
    output logic signed [REG_BITWIDTH-1:0] a0,
    output logic signed [REG_BITWIDTH-1:0] a1,
    output logic signed [REG_BITWIDTH-1:0] b0,
    output logic signed [REG_BITWIDTH-1:0] b1,
    output logic signed [REG_BITWIDTH-1:0] b2
);
    logic signed [REG_BITWIDTH-1:0] shadow_q [NUM_COEFFS];
    logic signed [REG_BITWIDTH-1:0] active_q [NUM_COEFFS];
    logic                           pending_q;
    logic                           do_apply;

    assign do_apply = apply && pending_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COEFFS; i++) shadow_q[i] <= '0;
        end else if (we) begin
            case (addr)
                ADDR_A0: shadow_q[0] <= wdata;
                ADDR_A1: shadow_q[1] <= wdata;
                ADDR_B0: shadow_q[2] <= wdata;
                ADDR_B1: shadow_q[3] <= wdata;
                ADDR_B2: shadow_q[4] <= wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COEFFS; i++) active_q[i] <= '0;
        end else if (do_apply) begin
            active_q <= shadow_q;
        end
    end

    // A commit seen while one is already pending is absorbed: one copy only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else if (pending_q) begin
            if (apply) pending_q <= 1'b0;
        end else if (commit) begin
            pending_q <= 1'b1;
        end
    end

    assign pending = pending_q;
    assign a0      = active_q[0];
    assign a1      = active_q[1];
    assign b0      = active_q[2];
    assign b1      = active_q[3];
    assign b2      = active_q[4];

endmodule

// File: rtl/fan_ctrl_scheduler.sv
// Fan controller sequencer: PWM prescaler, periodic ADC request, one-cycle PID strobe
// (valid in cycle k -> strobe in k+1), ADC timeout abort, atomic coefficient updates.
module fan_ctrl_scheduler
    import fan_ctrl_pkg::*;
#(
    parameter int ADC_BITWIDTH        = 8,
    parameter int REG_BITWIDTH        = 5,
    parameter int PRESCALE_BITWIDTH   = 8,
    parameter int SAMPLE_DIV_BITWIDTH = 8,
    parameter int TIMEOUT_CYCLES      = DEFAULT_TIMEOUT_CYCLES
) (
    input logic                clk_i,
    input logic                rstn_i,
    fan_ctrl_scheduler_if.slave bus
);
    localparam int              TO_W    = timeout_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t                         state_q;
    state_t                         state_d;
    logic [PRESCALE_BITWIDTH-1:0]   psc_q;
    logic [SAMPLE_DIV_BITWIDTH-1:0] tick_q;
    logic [TO_W-1:0]                to_q;
    logic [ADC_BITWIDTH-1:0]        adc_value_q;
    logic                           timeout_err_q;

    logic run;
    logic pwm_tick;
    logic sample_due;
    logic timeout_hit;
    logic capture;
    logic set_err;
    logic coeff_apply;

    // The prescaler keeps running through REQ/STROBE so the PWM never stalls.
    assign run         = bus.enable_i && (state_q != ST_IDLE);
    assign pwm_tick    = run && (psc_q >= bus.prescale_i);
    assign sample_due  = pwm_tick && (tick_q >= bus.sample_div_i);
    assign timeout_hit = (to_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        set_err = 1'b0;
        if (!bus.enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_COUNT;
                ST_COUNT:  if (sample_due) state_d = ST_REQ;
                ST_REQ: begin
                    if (bus.adc_valid_i) begin
                        capture = 1'b1;
                        state_d = ST_STROBE;
                    end else if (timeout_hit) begin
                        set_err = 1'b1;
                        state_d = ST_COUNT;
                    end
                end
                ST_STROBE: state_d = ST_COUNT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Coefficients only move outside the request..strobe window.
    assign coeff_apply = (state_q == ST_IDLE) ||
                         ((state_q == ST_COUNT) && (state_d == ST_REQ));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)               psc_q <= '0;
        else if (!run || pwm_tick) psc_q <= '0;
        else                       psc_q <= psc_q + PRESCALE_BITWIDTH'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tick_q <= '0;
        end else if (state_q != ST_COUNT) begin
            tick_q <= '0;
        end else if (pwm_tick) begin
            tick_q <= sample_due ? '0 : tick_q + SAMPLE_DIV_BITWIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                to_q <= '0;
        else if (state_q != ST_REQ) to_q <= '0;
        else                        to_q <= to_q + TO_W'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)      adc_value_q <= '0;
        else if (capture) adc_value_q <= bus.adc_data_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)      timeout_err_q <= 1'b0;
        else if (set_err) timeout_err_q <= 1'b1;
    end

    fan_ctrl_coeff_bank #(
        .REG_BITWIDTH(REG_BITWIDTH)
    ) u_coeff_bank (
        .clk     (clk_i),
        .rst_n   (rstn_i),
        .we      (bus.cfg_we_i),
        .addr    (bus.cfg_addr_i),
        .wdata   (bus.cfg_wdata_i),
        .commit  (bus.cfg_commit_i),
        .apply   (coeff_apply),
        .pending (bus.commit_pending_o),
        .a0      (bus.a0_o),
        .a1      (bus.a1_o),
        .b0      (bus.b0_o),
        .b1      (bus.b1_o),
        .b2      (bus.b2_o)
    );

    assign bus.adc_req_o        = (state_q == ST_REQ);
    assign bus.dataValid_STRB_o = (state_q == ST_STROBE);
    assign bus.clk_en_PWM_o     = pwm_tick;
    assign bus.ADC_value_o      = adc_value_q;
    assign bus.timeout_err_o    = timeout_err_q;

endmodule

// File: tb/tb_fan_ctrl_scheduler.sv
// Directed bench for fan_ctrl_scheduler: a timing table per prescale/sample_div setting,
// then hand sequences for coefficient commit, ADC timeout, enable drop and async reset.
module tb_fan_ctrl_scheduler;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fan_ctrl_scheduler_if bus ();

    fan_ctrl_scheduler #(.TIMEOUT_CYCLES(255)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] prescale;
        logic [7:0] sample_div;
        int         delay;
        logic [7:0] data;
        int         exp_tick_period;
        int         exp_first_req;
        int         exp_req_period;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [37:0] outs();
        return {bus.adc_req_o, bus.clk_en_PWM_o, bus.dataValid_STRB_o, bus.ADC_value_o,
                bus.a0_o, bus.a1_o, bus.b0_o, bus.b1_o, bus.b2_o,
                bus.commit_pending_o, bus.timeout_err_o};
    endfunction

    task automatic idle_inputs();
        bus.enable_i     = 1'b0;
        bus.prescale_i   = '0;
        bus.sample_div_i = '0;
        bus.adc_valid_i  = 1'b0;
        bus.adc_data_i   = '0;
        bus.cfg_we_i     = 1'b0;
        bus.cfg_addr_i   = '0;
        bus.cfg_wdata_i  = '0;
        bus.cfg_commit_i = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rstn = 1'b0;
        step();
        step();
        check("reset_outputs", outs(), 0);
        rstn = 1'b1;
        step();
    endtask

    // Returns at a negedge with the DUT in IDLE and enable just raised (cycle 0).
    task automatic restart(input logic [7:0] p, input logic [7:0] s);
        bus.enable_i    = 1'b0;
        bus.adc_valid_i = 1'b0;
        step();
        bus.prescale_i   = p;
        bus.sample_div_i = s;
        bus.enable_i     = 1'b1;
    endtask

    task automatic wait_req(output int at);
        at = -1;
        for (int k = 1; k <= 600 && at < 0; k++) begin
            step();
            if (bus.adc_req_o) at = k;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int t1, t2, r1, r2, valid_at, strobe_at, strobes;
        logic prev_req;
        logic [7:0] cap;
        apply_reset();
        t1 = -1; t2 = -1; r1 = -1; r2 = -1;
        valid_at = -1; strobe_at = -1; strobes = 0;
        prev_req = 1'b0; cap = '0;
        bus.prescale_i   = v.prescale;
        bus.sample_div_i = v.sample_div;
        bus.enable_i     = 1'b1;
        for (int k = 1; k <= 200 && r2 < 0; k++) begin
            step();
            if (bus.clk_en_PWM_o) begin
                if (t1 < 0) t1 = k;
                else if (t2 < 0) t2 = k;
            end
            if (bus.dataValid_STRB_o) begin
                strobes++;
                if (strobe_at < 0) begin
                    strobe_at = k;
                    cap = bus.ADC_value_o;
                end
            end
            if (bus.adc_req_o && !prev_req) begin
                if (r1 < 0) begin
                    r1 = k;
                    valid_at = k + v.delay;
                end else begin
                    r2 = k;
                end
            end
            prev_req = bus.adc_req_o;
            bus.adc_valid_i = (k == valid_at);
            bus.adc_data_i  = (k == valid_at) ? v.data : 8'h00;
        end
        bus.adc_valid_i = 1'b0;
        check($sformatf("vec%0d_tick_period", idx), t2 - t1, v.exp_tick_period);
        check($sformatf("vec%0d_first_req", idx), r1, v.exp_first_req);
        check($sformatf("vec%0d_strobe_latency", idx), strobe_at - valid_at, 1);
        check($sformatf("vec%0d_captured", idx), cap, v.data);
        check($sformatf("vec%0d_strobe_count", idx), strobes, 1);
        check($sformatf("vec%0d_req_period", idx), r2 - r1, v.exp_req_period);
    endtask

    initial begin
        int r, high, fall, rise2, strobes, any;
        logic err_start, err_after;
        logic [7:0] val_after;

        //             P      S      D  data    tick req1 req_period
        vecs[0] = '{8'd3, 8'd0, 2, 8'hA5, 4, 5,  8};
        vecs[1] = '{8'd0, 8'd9, 2, 8'h3C, 1, 11, 14};
        vecs[2] = '{8'd2, 8'd1, 0, 8'h81, 3, 7,  6};

        idle_inputs();
        for (int i = 0; i < 3; i++) run_vec(vecs[i], i);

        // Commit during REQ must not reach the active bank until the next COUNT->REQ.
        restart(8'd0, 8'd1);
        wait_req(r);
        check("coef_first_req", r, 3);
        bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 3'd0; bus.cfg_wdata_i = -5'sd3; bus.cfg_commit_i = 1'b1;
        step();
        bus.cfg_we_i = 1'b0; bus.cfg_commit_i = 1'b0;
        check("coef_pending_set", bus.commit_pending_o, 1);
        check("coef_a0_in_req", bus.a0_o, 0);
        bus.adc_valid_i = 1'b1; bus.adc_data_i = 8'h42;
        step();
        bus.adc_valid_i = 1'b0;
        check("coef_strobe", bus.dataValid_STRB_o, 1);
        check("coef_a0_in_strobe", bus.a0_o, 0);
        step();
        step();
        check("coef_a0_before_req", bus.a0_o, 0);
        step();
        check("coef_next_req", bus.adc_req_o, 1);
        check("coef_a0_applied", bus.a0_o, -3);
        check("coef_pending_clear", bus.commit_pending_o, 0);

        // In IDLE a write+commit lands one cycle after pending shows; a repeat commit is a no-op.
        bus.enable_i = 1'b0;
        step();
        bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 3'd3; bus.cfg_wdata_i = 5'sd7; bus.cfg_commit_i = 1'b1;
        step();
        bus.cfg_we_i = 1'b0;
        check("idle_pending", bus.commit_pending_o, 1);
        check("idle_b1_old", bus.b1_o, 0);
        step();
        bus.cfg_commit_i = 1'b0;
        check("idle_b1_new", bus.b1_o, 7);
        check("idle_repeat_commit", bus.commit_pending_o, 0);

        // ADC never answers: request held 255 cycles, sticky error, next request proceeds.
        restart(8'd0, 8'd0);
        high = 0; fall = -1; rise2 = -1; strobes = 0;
        err_start = 1'b1; err_after = 1'b0; val_after = '0;
        for (int k = 1; k <= 400 && rise2 < 0; k++) begin
            step();
            if (bus.dataValid_STRB_o) strobes++;
            if (bus.adc_req_o) begin
                if (fall >= 0) rise2 = k;
                else begin
                    if (high == 0) err_start = bus.timeout_err_o;
                    high++;
                end
            end else if (high > 0 && fall < 0) begin
                fall = k;
                err_after = bus.timeout_err_o;
                val_after = bus.ADC_value_o;
            end
        end
        check("to_err_before", err_start, 0);
        check("to_req_cycles", high, 255);
        check("to_err_set", err_after, 1);
        check("to_value_kept", val_after, 8'h42);
        check("to_no_strobe", strobes, 0);
        check("to_next_req_gap", rise2 - fall, 1);
        bus.adc_valid_i = 1'b1; bus.adc_data_i = 8'h99;
        step();
        bus.adc_valid_i = 1'b0;
        check("to_recover_strobe", bus.dataValid_STRB_o, 1);
        check("to_recover_value", bus.ADC_value_o, 8'h99);
        check("to_err_sticky", bus.timeout_err_o, 1);

        // Enable drops in the same cycle valid arrives: nothing captured or strobed.
        restart(8'd1, 8'd0);
        wait_req(r);
        check("en_first_req", r, 3);
        bus.enable_i = 1'b0; bus.adc_valid_i = 1'b1; bus.adc_data_i = 8'h11;
        any = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            any = any | {bus.adc_req_o, bus.dataValid_STRB_o, bus.clk_en_PWM_o};
        end
        bus.adc_valid_i = 1'b0;
        check("en_outputs_quiet", any, 0);
        check("en_value_kept", bus.ADC_value_o, 8'h99);

        // Reset asserted during STROBE clears everything immediately.
        restart(8'd0, 8'd0);
        wait_req(r);
        check("rst_first_req", r, 2);
        bus.adc_valid_i = 1'b1; bus.adc_data_i = 8'h5A;
        step();
        bus.adc_valid_i = 1'b0;
        check("rst_in_strobe", bus.dataValid_STRB_o, 1);
        check("rst_value_before", bus.ADC_value_o, 8'h5A);
        rstn = 1'b0;
        #1;
        check("rst_async_outputs", outs(), 0);
        step();
        idle_inputs();
        rstn = 1'b1;
        restart(8'd0, 8'd0);
        wait_req(r);
        check("rst_restart_req", r, 2);
        check("rst_restart_a0", bus.a0_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
